// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
//
// Bundles the fetch unit's instruction-memory bus, the redirect request from
// the execute stage and the decode-side valid/ready handshake.
//
//   imem_address   fetch address, meaningful while imem_rd_en=1
//   imem_rd_en     a fetch is issued this cycle
//   imem_data_out  instruction word returned MEM_LATENCY cycles after issue
//   redirect_valid control-flow change request
//   redirect_pc    new fetch target
//   instr_valid    prefetch FIFO head is valid
//   instr_ready    decode accepts the head this cycle
//   instr          FIFO head instruction word
//   instr_pc       address the head instruction was fetched from
//   fetch_fault    sticky flag: a misaligned redirect was taken
//
// master: the fetch unit. slave: the memory / core / decode side.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] imem_address;
  logic            imem_rd_en;
  logic [XLEN-1:0] imem_data_out;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            fetch_fault;

  modport master (
    output imem_address,
    output imem_rd_en,
    input  imem_data_out,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc,
    output fetch_fault
  );

  modport slave (
    input  imem_address,
    input  imem_rd_en,
    output imem_data_out,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc,
    input  fetch_fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Streams sequential fetches into a fixed-latency instruction memory, tracks
// the in-flight requests in a MEM_LATENCY-deep shift register, buffers the
// returned words in a DEPTH-entry prefetch FIFO and hands them to decode over
// a valid/ready handshake. A redirect flushes the FIFO and every in-flight
// fetch; a misaligned redirect target parks the unit in HALT with a sticky
// fault until an aligned redirect arrives.
//
// Parameters
//   XLEN          address / instruction width
//   RESET_VECTOR  first fetch address after reset
//   MEM_LATENCY   cycles from issue to imem_data_out valid (>= 1)
//   DEPTH         prefetch FIFO entries (power of two, >= 2)
//
// Ports
//   clk    clock, all state changes on the rising edge
//   reset  synchronous active-high reset (overrides redirect and handshake)
//   bus    instr_fetch_unit_if.master (memory bus, redirect, decode handshake)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 'h1000,
  parameter int              MEM_LATENCY  = 1,
  parameter int              DEPTH        = 4
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  // Wide enough for fifo_count + inflight_count without overflow.
  localparam int CNT_W = $clog2(DEPTH + MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              fetch_fault_q, fetch_fault_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;

  // In-flight fetch tracking: stage i holds a request issued i+1 cycles ago.
  logic [MEM_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
  logic [XLEN-1:0]        pipe_pc_q [MEM_LATENCY];
  logic [XLEN-1:0]        pipe_pc_d [MEM_LATENCY];

  // Prefetch FIFO.
  logic [XLEN-1:0]   fifo_instr_q [DEPTH];
  logic [XLEN-1:0]   fifo_instr_d [DEPTH];
  logic [XLEN-1:0]   fifo_pc_q    [DEPTH];
  logic [XLEN-1:0]   fifo_pc_d    [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [CNT_W-1:0]  inflight_cnt;
  logic              issue;
  logic              pop;
  logic              push;
  logic              redirect_aligned;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(pipe_valid_q[i]);
    end
  end

  // Credit check deliberately ignores a same-cycle pop: this keeps the issue
  // decision off the decode ready path at the cost of some throughput when
  // DEPTH < MEM_LATENCY+2.
  assign issue = !reset && (state_q == RUN) && !bus.redirect_valid &&
                 ((count_q + inflight_cnt) < DEPTH_C);

  assign pop              = (count_q != '0) && bus.instr_ready;
  // Writing at full is only legal when the head leaves in the same cycle; the
  // credit scheme means this guard never actually drops a returning word.
  assign push             = pipe_valid_q[MEM_LATENCY-1] && ((count_q != DEPTH_C) || pop);
  assign redirect_aligned = (bus.redirect_pc[1:0] == 2'b00);

  // In-flight shift register; a redirect kills every stage in one cycle so
  // stale words returning from memory are simply never captured.
  assign pipe_valid_d[0] = issue;
  assign pipe_pc_d[0]    = fetch_pc_q;

  for (genvar gi = 1; gi < MEM_LATENCY; gi++) begin : g_stage
    assign pipe_valid_d[gi] = pipe_valid_q[gi-1] & ~bus.redirect_valid;
    assign pipe_pc_d[gi]    = pipe_pc_q[gi-1];
  end

  always_comb begin
    state_d       = state_q;
    fetch_fault_d = fetch_fault_q;
    fetch_pc_d    = fetch_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;

    if (bus.redirect_valid) begin
      // A same-cycle handshake still completes (decode keeps that word);
      // the buffer is empty next cycle either way.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (redirect_aligned) begin
        fetch_pc_d    = bus.redirect_pc;
        state_d       = RUN;
        fetch_fault_d = 1'b0;
      end else begin
        state_d       = HALT;
        fetch_fault_d = 1'b1;
      end
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        fifo_instr_d[wr_ptr_q] = bus.imem_data_out;
        fifo_pc_d[wr_ptr_q]    = pipe_pc_q[MEM_LATENCY-1];
        wr_ptr_d               = wr_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      fetch_fault_q <= 1'b0;
      fetch_pc_q    <= RESET_VECTOR;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      pipe_valid_q  <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe_pc_q[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      state_q       <= state_d;
      fetch_fault_q <= fetch_fault_d;
      fetch_pc_q    <= fetch_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      pipe_valid_q  <= pipe_valid_d;
      pipe_pc_q     <= pipe_pc_d;
      fifo_instr_q  <= fifo_instr_d;
      fifo_pc_q     <= fifo_pc_d;
    end
  end

  assign bus.imem_address = fetch_pc_q;
  assign bus.imem_rd_en   = issue;
  assign bus.instr_valid  = (count_q != '0);
  assign bus.instr        = fifo_instr_q[rd_ptr_q];
  assign bus.instr_pc     = fifo_pc_q[rd_ptr_q];
  assign bus.fetch_fault  = fetch_fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam int          LAT_A = 1;
  localparam int          DEP_A = 4;
  localparam logic [31:0] RV_A  = 32'h0000_1000;
  localparam int          LAT_B = 3;
  localparam int          DEP_B = 8;
  localparam logic [31:0] RV_B  = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  instr_fetch_unit_if #(.XLEN(32)) if_a ();
  instr_fetch_unit_if #(.XLEN(32)) if_b ();

  instr_fetch_unit #(
    .XLEN(32), .RESET_VECTOR(RV_A), .MEM_LATENCY(LAT_A), .DEPTH(DEP_A)
  ) dut_a (
    .clk(clk), .reset(rst_a), .bus(if_a)
  );

  instr_fetch_unit #(
    .XLEN(32), .RESET_VECTOR(RV_B), .MEM_LATENCY(LAT_B), .DEPTH(DEP_B)
  ) dut_b (
    .clk(clk), .reset(rst_b), .bus(if_b)
  );

  // Memory contents: word at address a is a ^ 5A5A5A5A, so instr and
  // instr_pc can never be confused for one another.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Fixed-latency memory: returns junk unless a fetch was issued LAT cycles ago.
  logic [31:0] line_a [LAT_A];
  logic [31:0] line_b [LAT_B];
  always @(posedge clk) begin
    line_a[0] <= if_a.imem_rd_en ? if_a.imem_address : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT_A; i++) line_a[i] <= line_a[i-1];
    line_b[0] <= if_b.imem_rd_en ? if_b.imem_address : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT_B; i++) line_b[i] <= line_b[i-1];
  end
  assign if_a.imem_data_out = mem_word(line_a[LAT_A-1]);
  assign if_b.imem_data_out = mem_word(line_b[LAT_B-1]);

  int n_chk  = 0;
  int n_pass = 0;
  int tick   = 0;
  bit done_a = 1'b0;
  bit done_b = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: queues of buffered PCs and of in-flight (pc, arrival
  // cycle) pairs. Word contents follow from mem_word(pc).
  // ---------------------------------------------------------------------------
  logic [31:0] m_fifo   [2][$];
  logic [31:0] m_inf_pc [2][$];
  int          m_inf_t  [2][$];
  logic [31:0] m_pc       [2];
  bit          m_halt     [2];
  bit          m_fault    [2];
  bit          m_live     [2] = '{1'b0, 1'b0};
  bit          m_after    [2];

  task automatic model_cycle(
    input int id, input int lat, input int dep, input logic [31:0] rv,
    input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy,
    input logic rd_en, input logic [31:0] addr, input logic valid,
    input logic [31:0] ins, input logic [31:0] ipc, input logic fault);
    bit    exp_issue = 1'b0;
    bit    exp_valid = 1'b0;
    string tag;
    tag = $sformatf("%s t%0d", (id == 0) ? "A" : "B", tick);
    if (m_live[id]) begin
      exp_issue = !rst && !m_halt[id] && !redir &&
                  ((m_fifo[id].size() + m_inf_pc[id].size()) < dep);
      exp_valid = (m_fifo[id].size() != 0);
      chk({tag, " rd_en"}, 32'(rd_en), 32'(exp_issue));
      if (exp_issue) chk({tag, " imem_address"}, addr, m_pc[id]);
      chk({tag, " instr_valid"}, 32'(valid), 32'(exp_valid));
      if (exp_valid) begin
        chk({tag, " instr_pc"}, ipc, m_fifo[id][0]);
        chk({tag, " instr"}, ins, mem_word(m_fifo[id][0]));
      end else if (m_after[id]) begin
        chk({tag, " reset instr"}, ins, 32'h0);
        chk({tag, " reset instr_pc"}, ipc, 32'h0);
      end
      chk({tag, " fetch_fault"}, 32'(fault), 32'(m_fault[id]));
    end
    if (rst) begin
      m_fifo[id].delete(); m_inf_pc[id].delete(); m_inf_t[id].delete();
      m_pc[id] = rv; m_halt[id] = 1'b0; m_fault[id] = 1'b0;
      m_live[id] = 1'b1; m_after[id] = 1'b1;
    end else if (m_live[id]) begin
      m_after[id] = 1'b0;
      if (redir) begin
        m_fifo[id].delete(); m_inf_pc[id].delete(); m_inf_t[id].delete();
        if (rpc[1:0] == 2'b00) begin
          m_pc[id] = rpc; m_halt[id] = 1'b0; m_fault[id] = 1'b0;
        end else begin
          m_halt[id] = 1'b1; m_fault[id] = 1'b1;
        end
      end else begin
        if (exp_valid && rdy) void'(m_fifo[id].pop_front());
        if (m_inf_t[id].size() != 0 && m_inf_t[id][0] == tick) begin
          m_fifo[id].push_back(m_inf_pc[id].pop_front());
          void'(m_inf_t[id].pop_front());
        end
        if (exp_issue) begin
          m_inf_pc[id].push_back(m_pc[id]);
          m_inf_t[id].push_back(tick + lat);
          m_pc[id] = m_pc[id] + 32'd4;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0, LAT_A, DEP_A, RV_A, rst_a, if_a.redirect_valid, if_a.redirect_pc,
                if_a.instr_ready, if_a.imem_rd_en, if_a.imem_address, if_a.instr_valid,
                if_a.instr, if_a.instr_pc, if_a.fetch_fault);
    model_cycle(1, LAT_B, DEP_B, RV_B, rst_b, if_b.redirect_valid, if_b.redirect_pc,
                if_b.instr_ready, if_b.imem_rd_en, if_b.imem_address, if_b.instr_valid,
                if_b.instr, if_b.instr_pc, if_b.fetch_fault);
    tick++;
  end

  // ---------------------------------------------------------------------------
  // DUT A: RESET_VECTOR=0x1000, MEM_LATENCY=1, DEPTH=4
  // ---------------------------------------------------------------------------
  initial begin
    rst_a = 1'b1;
    if_a.redirect_valid = 1'b0;
    if_a.redirect_pc    = 32'h0;
    if_a.instr_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 66; c++) begin
      rst_a               = (c == 55);
      if_a.redirect_valid = (c == 31) || (c == 40) || (c == 48) || (c == 53) || (c == 55);
      case (c)
        31:      if_a.redirect_pc = 32'h0000_2000;
        40:      if_a.redirect_pc = 32'h0000_2002;
        48:      if_a.redirect_pc = 32'h0000_3000;
        53:      if_a.redirect_pc = 32'h0000_2006;
        default: if_a.redirect_pc = 32'h0000_4000;
      endcase
      if_a.instr_ready = !((c >= 10 && c < 20) || (c >= 30 && c < 32));
      @(negedge clk);
      case (c)
        0: begin
          chk("A c0 rd_en", 32'(if_a.imem_rd_en), 32'd1);
          chk("A c0 imem_address", if_a.imem_address, 32'h0000_1000);
        end
        1: chk("A c1 imem_address", if_a.imem_address, 32'h0000_1004);
        2: begin
          chk("A c2 instr_valid", 32'(if_a.instr_valid), 32'd1);
          chk("A c2 instr_pc", if_a.instr_pc, 32'h0000_1000);
          chk("A c2 instr", if_a.instr, 32'h5A5A_4A5A);
        end
        3: chk("A c3 instr_pc", if_a.instr_pc, 32'h0000_1004);
        19: begin
          chk("A c19 full rd_en", 32'(if_a.imem_rd_en), 32'd0);
          chk("A c19 instr_valid", 32'(if_a.instr_valid), 32'd1);
        end
        32: begin
          chk("A c32 instr_valid", 32'(if_a.instr_valid), 32'd0);
          chk("A c32 rd_en", 32'(if_a.imem_rd_en), 32'd1);
          chk("A c32 imem_address", if_a.imem_address, 32'h0000_2000);
        end
        33: chk("A c33 instr_valid", 32'(if_a.instr_valid), 32'd0);
        34: begin
          chk("A c34 instr_valid", 32'(if_a.instr_valid), 32'd1);
          chk("A c34 instr_pc", if_a.instr_pc, 32'h0000_2000);
        end
        41, 47: begin
          chk($sformatf("A c%0d fetch_fault", c), 32'(if_a.fetch_fault), 32'd1);
          chk($sformatf("A c%0d halt rd_en", c), 32'(if_a.imem_rd_en), 32'd0);
          chk($sformatf("A c%0d halt instr_valid", c), 32'(if_a.instr_valid), 32'd0);
        end
        49: begin
          chk("A c49 fetch_fault", 32'(if_a.fetch_fault), 32'd0);
          chk("A c49 rd_en", 32'(if_a.imem_rd_en), 32'd1);
          chk("A c49 imem_address", if_a.imem_address, 32'h0000_3000);
        end
        51: chk("A c51 instr_pc", if_a.instr_pc, 32'h0000_3000);
        54: chk("A c54 fetch_fault", 32'(if_a.fetch_fault), 32'd1);
        56: begin
          chk("A c56 fetch_fault", 32'(if_a.fetch_fault), 32'd0);
          chk("A c56 instr_valid", 32'(if_a.instr_valid), 32'd0);
          chk("A c56 rd_en", 32'(if_a.imem_rd_en), 32'd1);
          chk("A c56 imem_address", if_a.imem_address, 32'h0000_1000);
        end
        default: ;
      endcase
      @(posedge clk);
      #1;
    end
    done_a = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // DUT B: RESET_VECTOR=0xFFFFFFF8, MEM_LATENCY=3, DEPTH=8 (address wrap)
  // ---------------------------------------------------------------------------
  initial begin
    rst_b = 1'b1;
    if_b.redirect_valid = 1'b0;
    if_b.redirect_pc    = 32'h0;
    if_b.instr_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 40; c++) begin
      rst_b               = 1'b0;
      if_b.redirect_valid = (c == 30);
      if_b.redirect_pc    = 32'hFFFF_FFFC;
      if_b.instr_ready    = !(c >= 12 && c < 20 && (c % 3) != 0);
      @(negedge clk);
      case (c)
        0: begin
          chk("B c0 rd_en", 32'(if_b.imem_rd_en), 32'd1);
          chk("B c0 imem_address", if_b.imem_address, 32'hFFFF_FFF8);
        end
        1: chk("B c1 imem_address", if_b.imem_address, 32'hFFFF_FFFC);
        2: chk("B c2 imem_address", if_b.imem_address, 32'h0000_0000);
        3: chk("B c3 instr_valid", 32'(if_b.instr_valid), 32'd0);
        4: begin
          chk("B c4 instr_valid", 32'(if_b.instr_valid), 32'd1);
          chk("B c4 instr_pc", if_b.instr_pc, 32'hFFFF_FFF8);
          chk("B c4 instr", if_b.instr, 32'hA5A5_A5A2);
        end
        5: chk("B c5 instr_pc", if_b.instr_pc, 32'hFFFF_FFFC);
        6: chk("B c6 instr_pc", if_b.instr_pc, 32'h0000_0000);
        31: chk("B c31 imem_address", if_b.imem_address, 32'hFFFF_FFFC);
        32: chk("B c32 imem_address", if_b.imem_address, 32'h0000_0000);
        34: chk("B c34 instr_valid", 32'(if_b.instr_valid), 32'd0);
        35: begin
          chk("B c35 instr_valid", 32'(if_b.instr_valid), 32'd1);
          chk("B c35 instr_pc", if_b.instr_pc, 32'hFFFF_FFFC);
        end
        default: ;
      endcase
      @(posedge clk);
      #1;
    end
    done_b = 1'b1;
  end

  initial begin
    for (int t = 0; t < 1000; t++) begin
      if (done_a && done_b) break;
      @(posedge clk);
    end
    if (!(done_a && done_b)) begin
      n_chk++;
      $display("FAIL timeout: stimulus done=%0b%0b required 11", done_a, done_b);
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Parametrised instruction-fetch front end for the multicycle RISC-V core. Replaces the fixed single-fetch PC/IR register path with a fetch unit that streams sequential fetches into a fixed-latency instruction memory, buffers returned words in a small prefetch FIFO, and presents them to decode over a valid/ready handshake. Control-flow redirects flush the buffer and all in-flight fetches. Misaligned redirect targets halt fetching with a sticky fault.

## Interface
- XLEN, 32: address/instruction width.
- RESET_VECTOR, 32'h1000: first fetch address after reset.
- MEM_LATENCY, 1: cycles from issue (address presented) to `imem_data_out` valid; must be ≥1.
- DEPTH, 4: prefetch FIFO entries; power of 2, ≥2.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_address  out  XLEN  fetch address; valid when `imem_rd_en`=1.
- imem_rd_en  out  1  fetch issued this cycle.
- imem_data_out  in  XLEN  instruction word, MEM_LATENCY cycles after issue.
- redirect_valid  in  1  control-flow change request.
- redirect_pc  in  XLEN  new fetch target.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode accepts head.
- instr  out  XLEN  FIFO head instruction.
- instr_pc  out  XLEN  address of `instr`.
- fetch_fault  out  1  sticky; misaligned redirect taken.

## Operation
- State machine: RUN, HALT. Reset → RUN.
- RUN issue rule: `imem_rd_en` = (fifo_count + inflight_count < DEPTH) and no redirect this cycle. `imem_address` = fetch_pc (combinational from register). On issue, fetch_pc ← fetch_pc + 4, wrapping modulo 2^XLEN.
- In-flight tracking: MEM_LATENCY-stage shift register of {valid, pc}. Stage 0 loads {imem_rd_en, fetch_pc}. When the last stage is valid, {imem_data_out, pc} is written to the FIFO tail.
- Credit rule does not count a same-cycle pop. Full throughput (one instr/cycle) requires DEPTH ≥ MEM_LATENCY+2. Smaller DEPTH is legal and only reduces throughput; the FIFO never overflows.
- Handshake: transfer when `instr_valid` && `instr_ready`. `instr`/`instr_pc` hold stable while `instr_valid`=1 and `instr_ready`=0.
- Redirect with redirect_pc[1:0]=0: all in-flight valid bits cleared; FIFO emptied; fetch_pc ← redirect_pc. No issue this cycle; issue from redirect_pc next cycle. Returning stale data is discarded.
- Redirect with redirect_pc[1:0]≠0: same flush, then → HALT; `fetch_fault` ← 1. In HALT, `imem_rd_en`=0 and the FIFO stays empty.
- In HALT, an aligned redirect → RUN; `fetch_fault` clears; fetch resumes from the target. A misaligned redirect stays in HALT.
- Handshake in the same cycle as a redirect counts as completed (decode owns that word). The FIFO is empty the next cycle regardless.
- Reset overrides redirect and handshake.

## Timing
- Reset values: fetch_pc = RESET_VECTOR, FIFO empty, in-flight cleared, `instr_valid`=0, `imem_rd_en`=0 during the reset cycle, `fetch_fault`=0, `instr`/`instr_pc`=0.
- Reset deasserted in cycle 0: cycle 0 issues RESET_VECTOR.
- Fetch-to-decode latency: an issue in cycle N gives `instr_valid` in cycle N+MEM_LATENCY+1 (FIFO write is registered; no bypass).
- Redirect in cycle R: first new issue in R+1; first new `instr_valid` in R+MEM_LATENCY+2.
- FIFO pointers wrap modulo DEPTH. Full when count = DEPTH; a write and a pop in the same cycle at full or empty are both handled (count unchanged).

## Test plan
- Reset release, MEM_LATENCY=1, DEPTH=4, `instr_ready`=1, memory returns word = address: cycles 0,1,2… issue 0x1000, 0x1004, 0x1008…; `instr_valid` from cycle 2 with instr_pc 0x1000, 0x1004… consecutively, no bubbles.
- Backpressure: hold `instr_ready`=0 for 10 cycles. FIFO fills to 4, `imem_rd_en` drops once 4 are buffered or in flight. Release: words delivered in order 0x1000…, no loss or duplicate.
- Redirect to 0x2000 while 3 entries are buffered and 1 is in flight: next cycle `instr_valid`=0. `imem_address`=0x2000 issued in R+1. First delivered instr_pc = 0x2000 at R+3. No 0x10xx word appears after the redirect.
- Misaligned redirect to 0x2002: `fetch_fault`=1 from R+1, `imem_rd_en`=0 and `instr_valid`=0 indefinitely. Then aligned redirect to 0x3000: fault clears, fetch resumes at 0x3000.
- Wrap and latency: XLEN=32, RESET_VECTOR=32'hFFFF_FFF8, MEM_LATENCY=3, DEPTH=8. Issue sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000; first `instr_valid` in cycle 4; steady one instr/cycle.
- Reset asserted mid-stream with a redirect the same cycle: the next cycle shows FIFO empty, `fetch_fault`=0, and an issue of RESET_VECTOR; the redirect is ignored.
